// File: rtl/uart_param_xcvr.sv
// Parameterised UART transceiver: oversampled TX/RX with optional parity,
// 2-of-3 majority sampling on receive and a small RX FIFO with overrun
// detection. All logic runs from one clock at OVERSAMPLE x baud.
module uart_param_xcvr #(
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_bits,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_bits,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int CNT_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS);
  localparam int PTR_W   = $clog2(RX_FIFO_DEPTH);
  localparam int ENTRY_W = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] SAMPLE_A  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] SAMPLE_B  = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] SAMPLE_C  = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(RX_FIFO_DEPTH);
  localparam bit               HAS_PARITY = (PARITY_MODE != 0);
  localparam bit               ODD_PARITY = (PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  state_t               tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_bit_idx;
  logic                 tx_stop_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;

  // TX FSM: serialises one frame per accepted word; tx and tx_ready registered.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order or block scheduling.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state    <= IDLE;
      tx          <= 1'b1;
      tx_ready    <= 1'b1;
      tx_cnt      <= '0;
      tx_bit_idx  <= '0;
      tx_stop_idx <= 1'b0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          if (tx_valid) begin
            tx_shift <= tx_bits;
            tx_par   <= ODD_PARITY ? ~^tx_bits : ^tx_bits;
            tx_cnt   <= '0;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= START;
          end
        end
        default: begin
          if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end else begin
            tx_cnt <= '0;
            case (tx_state)
              START: begin
                tx_bit_idx <= '0;
                tx         <= tx_shift[0];
                tx_state   <= DATA;
              end
              DATA: begin
                if (tx_bit_idx == DATA_LAST) begin
                  if (HAS_PARITY) begin
                    tx       <= tx_par;
                    tx_state <= PARITY;
                  end else begin
                    tx          <= 1'b1;
                    tx_stop_idx <= 1'b0;
                    tx_state    <= STOP;
                  end
                end else begin
                  tx_bit_idx <= tx_bit_idx + BIT_W'(1);
                  tx_shift   <= tx_shift >> 1;
                  tx         <= tx_shift[1];
                end
              end
              PARITY: begin
                tx          <= 1'b1;
                tx_stop_idx <= 1'b0;
                tx_state    <= STOP;
              end
              STOP: begin
                if (tx_stop_idx == STOP_LAST) begin
                  tx_ready <= 1'b1;
                  tx_state <= IDLE;
                end else begin
                  tx_stop_idx <= 1'b1;
                end
              end
              default: tx_state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;
  logic       rx_prev;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser plus a delayed copy for start-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx};
      rx_prev <= rx_s;
    end
  end

  state_t               rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_bit_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 samp_a;
  logic                 samp_b;
  logic                 rx_perr;
  logic                 rx_fall;
  logic                 rx_maj;
  logic                 rx_decide;
  logic                 rx_par_exp;
  logic                 push;

  // rx_cnt holds the offset, within the current bit, of the sample on rx_s;
  // the falling-edge cycle is offset 0 of the start bit.
  assign rx_fall    = rx_prev & ~rx_s;
  assign rx_maj     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign rx_decide  = (rx_cnt == SAMPLE_C);
  assign rx_par_exp = ODD_PARITY ? ~^rx_shift : ^rx_shift;
  assign push       = (rx_state == STOP) && rx_decide;

  // RX FSM: majority-votes each bit and returns to IDLE at the stop sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state   <= IDLE;
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      rx_perr    <= 1'b0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= CNT_W'(1);
            rx_perr  <= 1'b0;
            rx_state <= START;
          end
        end
        default: begin
          rx_cnt <= (rx_cnt == BIT_LAST) ? '0 : rx_cnt + CNT_W'(1);
          if (rx_cnt == SAMPLE_A) samp_a <= rx_s;
          if (rx_cnt == SAMPLE_B) samp_b <= rx_s;
          if (rx_decide) begin
            case (rx_state)
              START:   if (rx_maj) rx_state <= IDLE;
              DATA:    rx_shift <= {rx_maj, rx_shift[DATA_BITS-1:1]};
              PARITY:  rx_perr  <= rx_maj ^ rx_par_exp;
              STOP:    rx_state <= IDLE;
              default: rx_state <= IDLE;
            endcase
          end
          if (rx_cnt == BIT_LAST) begin
            case (rx_state)
              START: begin
                rx_bit_idx <= '0;
                rx_state   <= DATA;
              end
              DATA: begin
                if (rx_bit_idx == DATA_LAST) begin
                  rx_state <= HAS_PARITY ? PARITY : STOP;
                end else begin
                  rx_bit_idx <= rx_bit_idx + BIT_W'(1);
                end
              end
              PARITY:  rx_state <= STOP;
              default: rx_state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO: entry = {data, frame_err, parity_err}
  // ---------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     fifo_count;
  logic               full;
  logic               pop;
  logic               fifo_write;

  assign push_entry = {rx_shift, ~rx_maj, HAS_PARITY & rx_perr};
  assign full       = (fifo_count == FULL_CNT);
  assign rx_valid   = (fifo_count != '0);
  assign pop        = rx_valid & rx_ready;
  assign fifo_write = push & (~full | pop);

  // Storage write; a full FIFO accepts a push only when the head leaves.
  // NOTE: the data array has no reset; rx_valid and the flag gating below
  // keep stale contents invisible, and leaving it out lets it map to RAM.
  always_ff @(posedge clock) begin
    if (fifo_write) fifo_mem[wr_ptr] <= push_entry;
  end

  // Pointers, occupancy and the overrun pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= push & full & ~pop;
      if (fifo_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_write, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign head          = fifo_mem[rd_ptr];
  assign rx_bits       = head[ENTRY_W-1:2];
  assign rx_frame_err  = rx_valid & head[1];
  assign rx_parity_err = rx_valid & head[0];

endmodule
